// File: rtl/dsp_logic_stage.sv
// dsp_logic_stage: operand staging for a combinational DSP48E2 logic op.
// A 2-entry skid FIFO holds operand pairs; the head pair drives the DSP
// operand bus and the DSP result is captured into a handshaked output
// register, giving a fully backpressured one-result-per-cycle stage.
module dsp_logic_stage #(
  parameter int width = 48
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  output logic [width-1:0] dsp_a,
  output logic [width-1:0] dsp_b,
  input  logic [width-1:0] dsp_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_y,
  output logic [31:0]      count
);

  // The DSP logic unit is 48 bits wide; anything outside 1..48 is unusable.
  generate
    if (width < 1 || width > 48) begin : g_width_check
      $error("dsp_logic_stage: width must be in 1..48");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [width-1:0]   e0_a_reg, e0_b_reg, e1_a_reg, e1_b_reg;
  logic [width-1:0]   e0_a_next, e0_b_next, e1_a_next, e1_b_next;
  logic               out_valid_reg;
  logic [width-1:0]   out_y_reg;
  logic [31:0]        count_reg;

  logic               head_valid;
  logic               push;
  logic               pop;
  logic               out_xfer;

  // in_ready depends only on registered occupancy (and the reset level),
  // never on out_ready, so no combinational path crosses the stage.
  assign in_ready   = reset && (state_reg != ST_FULL);
  assign head_valid = (state_reg != ST_EMPTY);
  assign push       = in_valid && in_ready;
  assign pop        = head_valid && (!out_valid_reg || out_ready);
  assign out_xfer   = out_valid_reg && out_ready;

  assign out_valid  = out_valid_reg;
  assign out_y      = out_y_reg;
  assign count      = count_reg;

  // Head entry drives the DSP bus; the bus is forced to zero when empty so
  // stale operands never toggle the DSP inputs.
  for (genvar gi = 0; gi < width; gi++) begin : g_bus
    assign dsp_a[gi] = e0_a_reg[gi] & head_valid;
    assign dsp_b[gi] = e0_b_reg[gi] & head_valid;
  end

  // Occupancy FSM next state and FIFO entry updates.
  always_comb begin
    state_next = state_reg;
    e0_a_next  = e0_a_reg;
    e0_b_next  = e0_b_reg;
    e1_a_next  = e1_a_reg;
    e1_b_next  = e1_b_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (push) begin
          e0_a_next  = in_a;
          e0_b_next  = in_b;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          // Head is consumed this edge, so the new pair becomes the head.
          e0_a_next  = in_a;
          e0_b_next  = in_b;
          state_next = ST_ONE;
        end else if (push) begin
          e1_a_next  = in_a;
          e1_b_next  = in_b;
          state_next = ST_FULL;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          e0_a_next  = e1_a_reg;
          e0_b_next  = e1_b_reg;
          state_next = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // Occupancy state and FIFO storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_EMPTY;
      e0_a_reg  <= '0;
      e0_b_reg  <= '0;
      e1_a_reg  <= '0;
      e1_b_reg  <= '0;
    end else begin
      state_reg <= state_next;
      e0_a_reg  <= e0_a_next;
      e0_b_reg  <= e0_b_next;
      e1_a_reg  <= e1_a_next;
      e1_b_reg  <= e1_b_next;
    end
  end

  // Output register: capture the DSP result on pop, otherwise drop valid
  // once the consumer takes the result; hold everything while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_y_reg     <= '0;
    end else if (pop) begin
      out_valid_reg <= 1'b1;
      out_y_reg     <= dsp_y;
    end else if (out_xfer) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Delivered-result counter, wrapping modulo 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (out_xfer) begin
      count_reg <= count_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_dsp_logic_stage.sv
// Bench for dsp_logic_stage: table vectors, hand-written corner sequences,
// and a queue-based reference model fed by a free-running monitor.
module tb_dsp_logic_stage;
  localparam int W = 48;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_ready;
  logic [W-1:0]  dsp_a, dsp_b, dsp_y, out_y;
  logic          out_valid;
  logic [31:0]   count;
  int            op = 0;

  int            n_cmp = 0;
  int            n_bad = 0;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   delivered = '0;
  logic          hold_prev = 1'b0;
  logic [W-1:0]  y_prev = '0;

  always #5 clock = ~clock;

  dsp_logic_stage #(.width(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_y(dsp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .count(count)
  );

  // Logic op as the DSP primitive would compute it (op 3 is asymmetric).
  function automatic logic [W-1:0] ref_op(int o, logic [W-1:0] a, logic [W-1:0] b);
    case (o)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Combinational DSP primitive attached to the operand bus.
  always_comb dsp_y = ref_op(op, dsp_a, dsp_b);

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < maxc) begin
      step();
      c++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", exp_q.size(), maxc);
    end
  endtask

  // Reference model: every accepted pair queues its expected result; every
  // delivered result must match the queue head; stalled outputs must hold.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      delivered = '0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", 64'(out_valid), 64'(1'b1));
        check("stall_y", 64'(out_y), 64'(y_prev));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0h required no result", out_y);
        end else begin
          check("result", 64'(out_y), 64'(exp_q.pop_front()));
        end
        delivered = delivered + 32'd1;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_op(op, in_a, in_b));
      hold_prev = out_valid && !out_ready;
      y_prev    = out_y;
    end
  end

  typedef struct {
    int           op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] p[4];
    logic [31:0]  cnt0;
    logic         got;

    vecs[0] = '{0, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F, 48'h0F0F_0000_0F0F};
    vecs[1] = '{1, 48'h0000_0000_0000, 48'h0000_0000_0001, 48'h0000_0000_0001};
    vecs[2] = '{2, 48'hFFFF_FFFF_FFFF, 48'h5555_5555_5555, 48'hAAAA_AAAA_AAAA};
    vecs[3] = '{3, 48'hFFFF_FFFF_FFFF, 48'h0000_FFFF_0000, 48'hFFFF_0000_FFFF};
    vecs[4] = '{0, 48'hFFFF_FFFF_FFFF, 48'h8000_0000_0001, 48'h8000_0000_0001};
    vecs[5] = '{2, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 48'h0000_0000_0000};

    // Reset held with traffic offered: everything stays zero.
    op = 0;
    in_valid = 1'b1;
    in_a = 48'hFFFF_0000_FFFF;
    in_b = 48'h0F0F_0F0F_0F0F;
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'(1'b0));
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_y", 64'(out_y), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_dsp_a", 64'(dsp_a), 64'(0));
    check("rst_dsp_b", 64'(dsp_b), 64'(0));

    // Release: first accept at the next edge, result one edge later.
    reset = 1'b1;
    step();
    in_valid = 1'b0;
    check("first_dsp_a", 64'(dsp_a), 64'(48'hFFFF_0000_FFFF));
    check("first_dsp_b", 64'(dsp_b), 64'(48'h0F0F_0F0F_0F0F));
    check("first_out_valid_early", 64'(out_valid), 64'(1'b0));
    step();
    check("first_out_valid", 64'(out_valid), 64'(1'b1));
    check("first_out_y", 64'(out_y), 64'(48'h0F0F_0000_0F0F));
    check("first_count_before", 64'(count), 64'(0));
    out_ready = 1'b1;
    step();
    check("first_count_after", 64'(count), 64'(1));
    check("first_out_valid_after", 64'(out_valid), 64'(1'b0));

    // Table vectors, one transaction each.
    for (int i = 0; i < 6; i++) begin
      op = vecs[i].op;
      in_a = vecs[i].a;
      in_b = vecs[i].b;
      in_valid = 1'b1;
      check("tbl_in_ready", 64'(in_ready), 64'(1'b1));
      step();
      in_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        if (out_valid) got = 1'b1;
        else step();
      end
      if (got) check($sformatf("tbl_y[%0d]", i), 64'(out_y), 64'(vecs[i].y));
      else begin
        n_cmp++;
        n_bad++;
        $display("FAIL tbl_timeout[%0d]: got no result required %0h", i, vecs[i].y);
      end
      step();
    end
    check("tbl_count", 64'(count), 64'(delivered));

    // Backpressure: three pairs absorbed, fourth waits until FIFO leaves FULL.
    out_ready = 1'b0;
    op = 3;
    for (int k = 0; k < 4; k++) p[k] = rnd48();
    in_valid = 1'b1;
    in_b = 48'h00FF_00FF_00FF;
    in_a = p[0]; step();
    in_a = p[1]; step();
    in_a = p[2]; step();
    check("bp_full_in_ready", 64'(in_ready), 64'(1'b0));
    in_a = p[3];
    repeat (3) begin
      step();
      check("bp_hold_in_ready", 64'(in_ready), 64'(1'b0));
    end
    check("bp_hold_y", 64'(out_y), 64'(ref_op(3, p[0], in_b)));
    out_ready = 1'b1;
    step();
    check("bp_drain1_y", 64'(out_y), 64'(ref_op(3, p[1], in_b)));
    check("bp_drain1_in_ready", 64'(in_ready), 64'(1'b1));
    step();
    in_valid = 1'b0;
    check("bp_drain2_y", 64'(out_y), 64'(ref_op(3, p[2], in_b)));
    step();
    check("bp_drain3_y", 64'(out_y), 64'(ref_op(3, p[3], in_b)));
    wait_drain(10);
    check("bp_count", 64'(count), 64'(delivered));

    // Streaming: back-to-back pairs with simultaneous push/pop in ONE.
    out_ready = 1'b1;
    op = 0;
    cnt0 = count;
    for (int i = 0; i < 100; i++) begin
      in_a = rnd48();
      in_b = rnd48();
      in_valid = 1'b1;
      check("stream_in_ready", 64'(in_ready), 64'(1'b1));
      step();
    end
    in_valid = 1'b0;
    wait_drain(10);
    check("stream_count", 64'(count - cnt0), 64'(100));

    // Random valid/ready traffic against the reference queue.
    op = 3;
    for (int i = 0; i < 500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = rnd48();
      in_b = rnd48();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(10);
    check("rand_count", 64'(count), 64'(delivered));

    // Reset while FULL with a pending result: immediate clear, no stale data.
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      in_a = rnd48();
      in_b = rnd48();
      step();
    end
    check("mid_full_in_ready", 64'(in_ready), 64'(1'b0));
    check("mid_full_out_valid", 64'(out_valid), 64'(1'b1));
    reset = 1'b0;
    #1;
    check("mid_in_ready", 64'(in_ready), 64'(1'b0));
    check("mid_out_valid", 64'(out_valid), 64'(1'b0));
    check("mid_out_y", 64'(out_y), 64'(0));
    check("mid_count", 64'(count), 64'(0));
    check("mid_dsp_a", 64'(dsp_a), 64'(0));
    check("mid_dsp_b", 64'(dsp_b), 64'(0));
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      step();
      check("mid_no_stale", 64'(out_valid), 64'(1'b0));
    end

    // Counter wrap from 0xFFFFFFFF to 0.
    force dut.count_reg = 32'hFFFF_FFFF;
    step();
    release dut.count_reg;
    delivered = 32'hFFFF_FFFF;
    check("wrap_preset", 64'(count), 64'(32'hFFFF_FFFF));
    in_a = rnd48();
    in_b = rnd48();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_drain(10);
    check("wrap_count", 64'(count), 64'(0));
    check("wrap_model", 64'(count), 64'(delivered));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
